image_select_ctrl: RTL
======================

IMAGE_SELECT_CTRL -- requirements
Module: image_select_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-input time before a button level is accepted (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter NUM_IMAGES, default 4, legal range 2..4, meaning the number of selectable images.
REQ-003 The block SHALL have parameter SLIDESHOW_CYCLES, default 150000000, meaning the auto-advance period; it is used only under SLIDESHOW_EN.
REQ-004 clk  input  1  50 MHz system clock; this is the only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 left_button  input  1  raw, asynchronous, active-high "previous image" button.
REQ-007 right_button  input  1  raw, asynchronous, active-high "next image" button.
REQ-008 center_button_a, center_button_b  input  1 each  raw, active-high; the center button counts as pressed only when both are high.
REQ-009 select_image  output  2  current image index, driven to the pixel generator.
REQ-010 select_change  output  1  one-cycle pulse in the cycle select_image takes a new value.
REQ-011 center_button  output  1  debounced center level, driven to the pixel generator.
REQ-012 slideshow_on  output  1  auto-advance active; tied 0 without SLIDESHOW_EN.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other logic; the center AND is formed after synchronization.
REQ-014 Each debouncer SHALL reload its counter on any change of the synchronized level, and SHALL update its stable level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 A press SHALL be a one-cycle pulse on a 0->1 transition of the stable level; a release SHALL produce no pulse.
REQ-016 A right press SHALL increment select_image, wrapping from NUM_IMAGES-1 to 0.
REQ-017 A left press SHALL decrement select_image, wrapping from 0 to NUM_IMAGES-1.
REQ-018 When left and right presses occur in the same cycle, select_image SHALL be unchanged and select_change SHALL stay 0.
REQ-019 select_image SHALL update on the clk edge after the press pulse, and select_change SHALL be high in exactly that cycle.
REQ-020 Total latency from a clean raw edge to the select_image update SHALL be 2 sync + DEBOUNCE_CYCLES + 2 cycles, and SHALL be documented as fixed.
REQ-021 A held button SHALL produce exactly one step; there is no auto-repeat.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no pulse.

Reset
REQ-023 While rst_n=0, select_image SHALL be 0, select_change SHALL be 0, center_button SHALL be 0, slideshow_on SHALL be 0, and all debounce counters and stable levels SHALL be 0.
REQ-024 Reset asserted mid-debounce SHALL discard the pending transition.
REQ-025 A button already held at reset release SHALL produce a press only after its full debounce time.
REQ-026 Reset deassertion SHALL be used as-is (asynchronous assert); no internal reset synchronizer is required.

Configuration
REQ-027 With SLIDESHOW_EN defined, each center press SHALL toggle slideshow_on.
REQ-028 With SLIDESHOW_EN defined and slideshow_on=1, a period counter SHALL advance select_image by +1 (with wrap) every SLIDESHOW_CYCLES cycles and pulse select_change.
REQ-029 With SLIDESHOW_EN defined, a manual left/right press SHALL take priority over an auto-advance in the same cycle and SHALL restart the period counter.
REQ-030 With SLIDESHOW_EN defined, turning slideshow_on on SHALL clear the period counter.
REQ-031 Without SLIDESHOW_EN, the period counter and toggle SHALL NOT be synthesized, slideshow_on SHALL be tied 0, and the center press SHALL only drive center_button.

Structure
REQ-032 A shared package image_sel_pkg SHALL hold SEL_W=2, DEBOUNCE_CYCLES_DEF, SLIDESHOW_CYCLES_DEF, and the counter width derived from DEBOUNCE_CYCLES.
REQ-033 Synchronizer, debounce and press detection SHALL be one sub-module, btn_debounce, instantiated three times (left, right, center-AND).

Verification (bench uses DEBOUNCE_CYCLES=4, SLIDESHOW_CYCLES=20, NUM_IMAGES=4)
REQ-034 Right held 10 cycles after reset -> select_image=1 and one select_change pulse, exactly 8 cycles after the raw edge.
REQ-035 Left pressed from select_image=0 -> select_image=3; then right -> 0 (both wraps).
REQ-036 Right pulses of 2 cycles repeated with gaps of 2 -> no change, select_change never high.
REQ-037 Left and right raised in the same cycle and held 10 cycles -> select_image unchanged, no pulse.
REQ-038 SLIDESHOW_EN: center press, then 60 idle cycles -> slideshow_on=1 and select_image 0->1->2->3 at 20-cycle intervals; a right press at cycle 10 of a period -> immediate +1, and the next auto step comes 20 cycles later.
REQ-039 rst_n pulsed low during a debounce count at select_image=2 -> select_image=0 and no pulse after release until a fresh full debounce.

Source files
------------

// File: rtl/image_sel_pkg.sv
// Shared constants for the image selector: select width, default timing and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package image_sel_pkg;

    localparam int SEL_W                = 2;
    localparam int DEBOUNCE_CYCLES_DEF  = 1000000;    // 20 ms at 50 MHz
    localparam int SLIDESHOW_CYCLES_DEF = 150000000;  // 3 s at 50 MHz

    // Width of a counter that runs 0 .. cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DB_CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/image_select_ctrl_btn_debounce.sv
// Button front end: 2-flop sync per raw bit, AND of synced bits, debounce, rising-edge press pulse.
// Latency: raw edge -> press_o pulse is 2 + DEBOUNCE_CYCLES + 1 cycles, fixed.
// Backpressure: none; the press pulse is one cycle wide and cannot be stalled.
//
// Ports: clk, rst_n (async active-low); raw_i[N_IN-1:0] raw asynchronous inputs;
//        level_o debounced level; press_o one-cycle pulse on a 0->1 of level_o.
module btn_debounce
    import image_sel_pkg::*;
#(
    parameter int N_IN            = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] raw_i,
    output logic            level_o,
    output logic            press_o
);
    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  meta_q;
    logic [N_IN-1:0]  sync_q;
    logic             sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic             press_q, press_d;

    // Multi-bit buttons count as pressed only when every synchronized bit is high.
    assign sample = &sync_q;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        // The counter only runs while the sample disagrees with the accepted level;
        // any return to the accepted level reloads it.
        if (sample != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Registered rise detect: adds the one cycle that keeps total latency fixed.
        press_d = stable_q & ~stable_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= '0;
            sync_q        <= '0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            meta_q        <= raw_i;
            sync_q        <= meta_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= press_d;
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/image_select_ctrl.sv
// Image selector: debounced left/right buttons step select_image with wrap; optional slideshow.
// Latency: raw button edge -> select_image update is 2 + DEBOUNCE_CYCLES + 2 cycles, fixed.
// Backpressure: none; every accepted press is applied in the following cycle.
//
// Ports: clk, rst_n (async active-low); left_button/right_button raw step buttons;
//        center_button_a/_b raw center pair (pressed when both high);
//        select_image current index; select_change one-cycle pulse on update;
//        center_button debounced center level; slideshow_on auto-advance active.
// Build option: define SLIDESHOW_EN to add center-toggled auto-advance every
//               SLIDESHOW_CYCLES cycles; otherwise slideshow_on is tied 0.
module image_select_ctrl
    import image_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int NUM_IMAGES       = 4,
    parameter int SLIDESHOW_CYCLES = SLIDESHOW_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left_button,
    input  logic             right_button,
    input  logic             center_button_a,
    input  logic             center_button_b,
    output logic [SEL_W-1:0] select_image,
    output logic             select_change,
    output logic             center_button,
    output logic             slideshow_on
);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IMAGES - 1);

    logic             press_l, press_r, press_c;
    logic             unused_level_l, unused_level_r;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] sel_inc, sel_dec;
    logic             chg_q;

    btn_debounce #(.N_IN(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (left_button),
        .level_o (unused_level_l),
        .press_o (press_l)
    );

    btn_debounce #(.N_IN(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (right_button),
        .level_o (unused_level_r),
        .press_o (press_r)
    );

    // Both center contacts are synchronized individually and ANDed inside.
    btn_debounce #(.N_IN(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_center (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   ({center_button_a, center_button_b}),
        .level_o (center_button),
        .press_o (press_c)
    );

`ifdef SLIDESHOW_EN
    localparam int               PER_W    = cnt_width(SLIDESHOW_CYCLES);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SLIDESHOW_CYCLES - 1);

    logic [PER_W-1:0] per_q, per_d;
    logic             slide_q, slide_d;
    logic             auto_step;

    always_comb begin
        per_d     = '0;
        auto_step = 1'b0;
        slide_d   = slide_q ^ press_c;
        // Counter idles at zero while off, so switching on starts a fresh period.
        // Any manual press wins over the auto step and restarts the period.
        if (slide_q && !(press_l || press_r)) begin
            if (per_q == PER_LAST) begin
                auto_step = 1'b1;
            end else begin
                per_d = per_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q   <= '0;
            slide_q <= 1'b0;
        end else begin
            per_q   <= per_d;
            slide_q <= slide_d;
        end
    end

    assign slideshow_on = slide_q;
`else
    // Center press only feeds center_button in this build.
    logic unused_press_c;
    assign unused_press_c = press_c;
    assign slideshow_on   = 1'b0;
`endif

    always_comb begin
        sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        sel_dec = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
        sel_d   = sel_q;
        // Simultaneous left+right presses cancel.
        if (press_r && !press_l) begin
            sel_d = sel_inc;
        end else if (press_l && !press_r) begin
            sel_d = sel_dec;
        end
`ifdef SLIDESHOW_EN
        else if (auto_step) begin
            sel_d = sel_inc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            chg_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            chg_q <= (sel_d != sel_q);
        end
    end

    assign select_image  = sel_q;
    assign select_change = chg_q;

endmodule
